// File: rtl/cpu_trap_ctrl_pkg.sv
// Trap sequencer shared definitions: widths, CSR addresses,
// exception cause codes and FSM state encoding.
package cpu_trap_ctrl_pkg;

  localparam int TRAP_XLEN    = 32;
  localparam int TRAP_CAUSE_W = 4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [TRAP_CAUSE_W-1:0] CAUSE_ECALL_M    = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RET    = 2'd3
  } trap_state_e;

endpackage

// File: rtl/cpu_trap_ctrl_if.sv
// CSR file port bundle: write port plus the trap read port.
// master = trap sequencer, slave = CSR file (combinational read).
interface cpu_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wenable;
  logic [11:0]     csr_raddr_trap;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output csr_waddr,
    output csr_wdata,
    output csr_wenable,
    output csr_raddr_trap,
    input  csr_rdata
  );

  modport slave (
    input  csr_waddr,
    input  csr_wdata,
    input  csr_wenable,
    input  csr_raddr_trap,
    output csr_rdata
  );
endinterface

// File: rtl/cpu_trap_ctrl.sv
// Trap/mret sequencer in front of the machine CSR file.
// Ports: i_clk/i_rst (sync, active high); trap/mret requests and
// pipeline CSR write from writeback; csr (CSR file bus, master);
// o_flush/o_stall/o_redirect_* to the pipeline; o_mcause_q.
module cpu_trap_ctrl
  import cpu_trap_ctrl_pkg::*;
#(
  parameter int XLEN    = TRAP_XLEN,
  parameter int CAUSE_W = TRAP_CAUSE_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_trap_req,
  input  logic [CAUSE_W-1:0] i_trap_cause,
  input  logic [XLEN-1:0]    i_trap_pc,
  input  logic               i_mret_req,
  input  logic               i_bubble_w,
  input  logic               i_pipe_csr_we,
  input  logic [11:0]        i_pipe_csr_waddr,
  input  logic [XLEN-1:0]    i_pipe_csr_wdata,
  cpu_trap_ctrl_if.master    csr,
  output logic               o_trap_active,
  output logic               o_flush,
  output logic               o_stall,
  output logic               o_redirect_valid,
  output logic [XLEN-1:0]    o_redirect_pc,
  output logic [CAUSE_W-1:0] o_mcause_q
);

  trap_state_e        r_state;
  trap_state_e        w_next;
  logic [XLEN-1:0]    r_pc;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] r_mcause;
  logic               w_take_trap;

  logic               w_we;
  logic [11:0]        w_waddr;
  logic [XLEN-1:0]    w_wdata;
  logic [11:0]        w_raddr;
  logic               w_flush;
  logic               w_stall;
  logic               w_rv;
  logic [XLEN-1:0]    w_rpc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_cause  <= '0;
      r_mcause <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_trap) begin
        r_pc    <= i_trap_pc;
        r_cause <= i_trap_cause;
      end
      if (r_state == ST_SAVE) r_mcause <= r_cause;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_take_trap = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_raddr     = '0;
    w_flush     = 1'b0;
    w_stall     = 1'b0;
    w_rv        = 1'b0;
    w_rpc       = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_we    = i_pipe_csr_we;
        w_waddr = i_pipe_csr_waddr;
        w_wdata = i_pipe_csr_wdata;
        // trap has priority over mret in the same slot
        if (i_trap_req && !i_bubble_w) begin
          w_next      = ST_SAVE;
          w_take_trap = 1'b1;
        end else if (i_mret_req && !i_bubble_w) begin
          w_next = ST_RET;
        end
      end
      ST_SAVE: begin
        w_we    = 1'b1;
        w_waddr = CSR_MEPC;
        w_wdata = r_pc;
        w_flush = 1'b1;
        w_stall = 1'b1;
        w_next  = ST_VECTOR;
      end
      ST_VECTOR: begin
        w_raddr = CSR_MTVEC;
        w_rv    = 1'b1;
        w_rpc   = csr.csr_rdata & ~XLEN'(3);
        w_flush = 1'b1;
        w_next  = ST_IDLE;
      end
      ST_RET: begin
        w_raddr = CSR_MEPC;
        w_rv    = 1'b1;
        w_rpc   = csr.csr_rdata & ~XLEN'(3);
        w_flush = 1'b1;
        w_next  = ST_IDLE;
      end
    endcase
    // reset aborts the sequence: no mepc write, no redirect
    if (i_rst && r_state != ST_IDLE) begin
      w_we  = 1'b0;
      w_rv  = 1'b0;
      w_rpc = '0;
    end
  end

  assign csr.csr_wenable    = w_we;
  assign csr.csr_waddr      = w_waddr;
  assign csr.csr_wdata      = w_wdata;
  assign csr.csr_raddr_trap = w_raddr;

  assign o_trap_active    = (r_state != ST_IDLE);
  assign o_flush          = w_flush;
  assign o_stall          = w_stall;
  assign o_redirect_valid = w_rv;
  assign o_redirect_pc    = w_rpc;
  assign o_mcause_q       = r_mcause;

endmodule
